// File: rtl/ctrl_pkg.sv
// Shared state and PC-select encodings for the multi-cycle control sequencer,
// plus the bundle of control strobes it drives into the datapath.
package ctrl_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       ir_wr;
        logic       pc_wr;
        logic [1:0] pc_sel;
        logic       reg_wr;
        logic       mem_wr;
        logic       retire;
    } ctrl_out_t;

    // Completing an instruction always pairs the PC update with the retire pulse.
    function automatic ctrl_out_t retire_with(input ctrl_out_t base, input logic [1:0] sel);
        ctrl_out_t o;
        o        = base;
        o.pc_wr  = 1'b1;
        o.pc_sel = sel;
        o.retire = 1'b1;
        return o;
    endfunction

endpackage

// File: rtl/mc_perf_cnt.sv
// Free-running cycle and retired-instruction counters for the sequencer;
// both wrap modulo 2^CNT_W and clear on synchronous reset.
module mc_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             retire_i,
    output logic [CNT_W-1:0] cyc_cnt_o,
    output logic [CNT_W-1:0] ret_cnt_o
);

    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    always_comb begin
        cyc_d = cyc_q + 1'b1;
        ret_d = ret_q;
        if (retire_i) begin
            ret_d = ret_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign cyc_cnt_o = cyc_q;
    assign ret_cnt_o = ret_q;

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer gating all architectural writes.
// Defining MC_SEQ_PERF_EN adds the cyc_cnt/ret_cnt performance counter ports.
module mc_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_RegWr,
    input  logic             dec_MemToReg,
    input  logic             dec_MemWr,
    input  logic             dec_Branch,
    input  logic             dec_Jump,
    input  logic             br_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             IRWr,
    output logic             PCWr,
    output logic [1:0]       pc_sel,
    output logic             RegWrEn,
    output logic             MemWrEn,
    output logic             retire,
    output logic             err,
`ifdef MC_SEQ_PERF_EN
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
`endif
    output logic [2:0]       state
);

    // The wait counter only needs to reach TIMEOUT-1; ready on that cycle still wins.
    localparam int unsigned      WaitW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic             err_q, err_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             timeout;
    ctrl_out_t        ctl, ctl_out;

    assign timeout = (TIMEOUT != 0) && (wait_q == WaitLast);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        ctl     = '0;

        unique case (state_q)
            ST_FETCH: begin
                ctl.imem_req = 1'b1;
                if (imem_ready) begin
                    ctl.ir_wr = 1'b1;
                    state_d   = ST_DECODE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_Jump && !dec_RegWr) begin
                    ctl     = retire_with(ctl, PC_JMP);
                    state_d = ST_FETCH;
                end else if (dec_Branch) begin
                    ctl     = retire_with(ctl, br_taken ? PC_BR : PC_SEQ);
                    state_d = ST_FETCH;
                end else if (dec_MemToReg || dec_MemWr) begin
                    state_d = ST_MEM;
                end else if (dec_RegWr) begin
                    state_d = ST_WB;
                end else begin
                    ctl     = retire_with(ctl, PC_SEQ);
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                ctl.dmem_req = 1'b1;
                ctl.mem_wr   = dec_MemWr & dmem_ready;
                if (dmem_ready) begin
                    if (dec_MemToReg) begin
                        state_d = ST_WB;
                    end else begin
                        ctl     = retire_with(ctl, PC_SEQ);
                        state_d = ST_FETCH;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                ctl.reg_wr = 1'b1;
                ctl        = retire_with(ctl, dec_Jump ? PC_JMP : PC_SEQ);
                state_d    = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Restarting on every state change clears the count on entry to FETCH and MEM.
        wait_d = (state_d != state_q) ? '0 : wait_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    // Holding reset silences every strobe, including one for an aborted MEM access.
    assign ctl_out  = rst ? '0 : ctl;
    assign imem_req = ctl_out.imem_req;
    assign dmem_req = ctl_out.dmem_req;
    assign IRWr     = ctl_out.ir_wr;
    assign PCWr     = ctl_out.pc_wr;
    assign pc_sel   = ctl_out.pc_sel;
    assign RegWrEn  = ctl_out.reg_wr;
    assign MemWrEn  = ctl_out.mem_wr;
    assign retire   = ctl_out.retire;
    assign err      = err_q & ~rst;
    assign state    = rst ? ST_FETCH : state_q;

`ifdef MC_SEQ_PERF_EN
    mc_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk_i    (clk),
        .rst_i    (rst),
        .retire_i (retire),
        .cyc_cnt_o(cyc_cnt),
        .ret_cnt_o(ret_cnt)
    );
`else
    // CNT_W only sizes the optional counters; nothing to build without them.
    if (CNT_W == 0) begin : g_no_perf
    end
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: a timeline model predicts every strobe event,
// a negedge monitor pops and compares whenever the DUT shows one.
module tb_mc_sequencer;

    localparam int unsigned TO = 8;

    // dec bit order: {RegWr, MemToReg, MemWr, Branch, Jump}
    localparam logic [4:0] ADDU = 5'b10000;
    localparam logic [4:0] LW   = 5'b11000;
    localparam logic [4:0] SW   = 5'b00100;
    localparam logic [4:0] BEQ  = 5'b00010;
    localparam logic [4:0] J    = 5'b00001;
    localparam logic [4:0] JAL  = 5'b10001;
    localparam logic [4:0] BJ   = 5'b00011;
    localparam logic [4:0] NOP  = 5'b00000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dec_RegWr = 1'b0, dec_MemToReg = 1'b0, dec_MemWr = 1'b0;
    logic dec_Branch = 1'b0, dec_Jump = 1'b0, br_taken = 1'b0;
    logic imem_ready = 1'b0, dmem_ready = 1'b0;
    logic imem_req, dmem_req, IRWr, PCWr, RegWrEn, MemWrEn, retire, err;
    logic [1:0] pc_sel;
    logic [2:0] state;
`ifdef MC_SEQ_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    mc_sequencer #(
        .TIMEOUT(TO),
        .CNT_W  (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dec_RegWr   (dec_RegWr),
        .dec_MemToReg(dec_MemToReg),
        .dec_MemWr   (dec_MemWr),
        .dec_Branch  (dec_Branch),
        .dec_Jump    (dec_Jump),
        .br_taken    (br_taken),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .imem_req    (imem_req),
        .dmem_req    (dmem_req),
        .IRWr        (IRWr),
        .PCWr        (PCWr),
        .pc_sel      (pc_sel),
        .RegWrEn     (RegWrEn),
        .MemWrEn     (MemWrEn),
        .retire      (retire),
        .err         (err),
`ifdef MC_SEQ_PERF_EN
        .cyc_cnt     (cyc_cnt),
        .ret_cnt     (ret_cnt),
`endif
        .state       (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] c;
        logic [2:0]  st;
        logic        ireq, dreq, irwr, pcwr;
        logic [1:0]  sel;
        logic        rwe, mwe, ret, er;
    } ev_t;

    ev_t exp_q[$];
    ev_t got_ev, want_ev;
    int  total = 0;
    int  bad   = 0;

    function automatic ev_t ev(input int c, input int st, input bit ireq, input bit dreq,
                               input bit irwr, input bit pcwr, input bit [1:0] sel,
                               input bit rwe, input bit mwe, input bit ret);
        ev_t e;
        e.c = 32'(c); e.st = 3'(st); e.ireq = ireq; e.dreq = dreq; e.irwr = irwr;
        e.pcwr = pcwr; e.sel = sel; e.rwe = rwe; e.mwe = mwe; e.ret = ret; e.er = 1'b0;
        return e;
    endfunction

    function automatic string fmt(input ev_t e);
        return $sformatf("cyc=%0d st=%0d ireq=%0b dreq=%0b irwr=%0b pcwr=%0b sel=%02b rwe=%0b mwe=%0b ret=%0b err=%0b",
                         e.c, e.st, e.ireq, e.dreq, e.irwr, e.pcwr, e.sel, e.rwe, e.mwe, e.ret, e.er);
    endfunction

    // Monitor: any strobe, or a completed data handshake, is an observable event.
    always @(negedge clk) begin
        if (IRWr | PCWr | RegWrEn | MemWrEn | retire | (dmem_req & dmem_ready)) begin
            got_ev.c = 32'(cyc); got_ev.st = state; got_ev.ireq = imem_req;
            got_ev.dreq = dmem_req; got_ev.irwr = IRWr; got_ev.pcwr = PCWr;
            got_ev.sel = pc_sel; got_ev.rwe = RegWrEn; got_ev.mwe = MemWrEn;
            got_ev.ret = retire; got_ev.er = err;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got %s required none", fmt(got_ev));
            end else begin
                want_ev = exp_q.pop_front();
                if (got_ev !== want_ev) begin
                    bad++;
                    $display("FAIL event: got %s required %s", fmt(got_ev), fmt(want_ev));
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic [4:0] d);
        {dec_RegWr, dec_MemToReg, dec_MemWr, dec_Branch, dec_Jump} = d;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int k = 0; k < n; k++) begin
            imem_ready = 1'($urandom());
            dmem_ready = 1'($urandom());
            set_dec(5'($urandom()));
            @(negedge clk);
            chk("reset_outputs", {imem_req, dmem_req, IRWr, PCWr, pc_sel, RegWrEn, MemWrEn,
                                  retire, err, state}, 0);
            step();
        end
        rst = 1'b0;
    endtask

    // Entered at the start of the instruction's first FETCH cycle; predicts its events from
    // the instruction class, the fetch wait di and the data wait dm, then drives the readies.
    task automatic run_instr(input logic [4:0] d, input logic bt, input int di, input int dm);
        logic rw, ml, mw, br, jp;
        int t, e, m, done, mem_lo, mem_hi;
        {rw, ml, mw, br, jp} = d;
        t = cyc;
        e = t + di + 2;
        mem_lo = -1;
        mem_hi = -2;
        exp_q.push_back(ev(t + di, 0, 1, 0, 1, 0, 2'b00, 0, 0, 0));
        if (jp && !rw) begin
            exp_q.push_back(ev(e, 2, 0, 0, 0, 1, 2'b10, 0, 0, 1));
            done = e;
        end else if (br) begin
            exp_q.push_back(ev(e, 2, 0, 0, 0, 1, bt ? 2'b01 : 2'b00, 0, 0, 1));
            done = e;
        end else if (ml || mw) begin
            m = e + 1 + dm;
            mem_lo = e + 1;
            mem_hi = m;
            if (ml) begin
                exp_q.push_back(ev(m, 3, 0, 1, 0, 0, 2'b00, 0, 0, 0));
                exp_q.push_back(ev(m + 1, 4, 0, 0, 0, 1, jp ? 2'b10 : 2'b00, 1, 0, 1));
                done = m + 1;
            end else begin
                exp_q.push_back(ev(m, 3, 0, 1, 0, 1, 2'b00, 0, 1, 1));
                done = m;
            end
        end else if (rw) begin
            exp_q.push_back(ev(e + 1, 4, 0, 0, 0, 1, jp ? 2'b10 : 2'b00, 1, 0, 1));
            done = e + 1;
        end else begin
            exp_q.push_back(ev(e, 2, 0, 0, 0, 1, 2'b00, 0, 0, 1));
            done = e;
        end
        set_dec(d);
        br_taken = bt;
        for (int c = t; c <= done; c++) begin
            if (c < t + di)       imem_ready = 1'b0;
            else if (c == t + di) imem_ready = 1'b1;
            else                  imem_ready = 1'($urandom());
            if (c >= mem_lo && c < mem_hi) dmem_ready = 1'b0;
            else if (c == mem_hi)          dmem_ready = 1'b1;
            else                           dmem_ready = 1'($urandom());
            step();
        end
    endtask

    // Hold both readies low until the last wait cycle, then expect a sticky, silent TRAP.
    task automatic hold_to_trap(input string nm, input int last, input int wait_st);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        while (cyc < last) step();
        @(negedge clk);
        chk({nm, "_last_wait_state"}, state, wait_st);
        chk({nm, "_last_wait_err"}, err, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            imem_ready = 1'($urandom());
            dmem_ready = 1'($urandom());
            @(negedge clk);
            chk({nm, "_trap_state"}, state, 5);
            chk({nm, "_trap_err"}, err, 1);
            chk({nm, "_trap_outputs"}, {imem_req, dmem_req, IRWr, PCWr, pc_sel, RegWrEn,
                                        MemWrEn, retire}, 0);
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        do_reset(3);

        for (int i = 0; i < 10; i++) run_instr(ADDU, 1'b0, 0, 0);
`ifdef MC_SEQ_PERF_EN
        chk("perf_cyc_cnt", cyc_cnt, 40);
        chk("perf_ret_cnt", ret_cnt, 10);
`endif

        run_instr(LW,   1'b0, 0, 3);
        run_instr(BEQ,  1'b1, 0, 0);
        run_instr(BEQ,  1'b0, 0, 0);
        run_instr(JAL,  1'b0, 0, 0);
        run_instr(J,    1'b0, 0, 0);
        run_instr(BJ,   1'b1, 0, 0);
        run_instr(SW,   1'b0, 1, 0);
        run_instr(NOP,  1'b0, 2, 0);
        run_instr(LW,   1'b0, 7, 7);
        run_instr(SW,   1'b0, 7, 7);

        for (int i = 0; i < 150; i++) begin
            logic [4:0] d;
            int di, dm;
            d = 5'($urandom());
            if (d[3] && d[2]) d[2] = 1'b0;
            di = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0;
            dm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0;
            run_instr(d, 1'($urandom()), di, dm);
        end

        // sw killed by reset in its second MEM cycle, dmem_ready arriving in that cycle
        t = cyc;
        set_dec(SW);
        br_taken = 1'b0;
        exp_q.push_back(ev(t, 0, 1, 0, 1, 0, 2'b00, 0, 0, 0));
        imem_ready = 1'b1; dmem_ready = 1'b0; step();
        imem_ready = 1'b0; step();
        step();
        chk("abort_mem_entry", state, 3);
        step();
        rst = 1'b1; dmem_ready = 1'b1;
        @(negedge clk);
        chk("abort_memwren", MemWrEn, 0);
        chk("abort_retire", retire, 0);
        step();
        rst = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        chk("abort_next_state", state, 0);
        step();
        run_instr(ADDU, 1'b0, 2, 0);

        // load whose data memory never answers
        t = cyc;
        set_dec(LW);
        exp_q.push_back(ev(t, 0, 1, 0, 1, 0, 2'b00, 0, 0, 0));
        imem_ready = 1'b1; dmem_ready = 1'b0; step();
        hold_to_trap("dmem_timeout", t + 10, 3);

        do_reset(2);
        t = cyc;
        hold_to_trap("imem_timeout", t + 7, 0);

        do_reset(2);
        run_instr(ADDU, 1'b0, 0, 0);
        run_instr(JAL,  1'b0, 0, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
